// File: rtl/button_event_arbiter.sv
// Synchronises N push buttons, latches presses as sticky pending bits and serialises them
// round-robin over valid/ready with a shared lockout timer. Define BTN_REPEAT_EN for auto-repeat.
module button_event_arbiter #(
    parameter int N_BTN       = 4,
    parameter int LOCKOUT_CYC = 100_000_000,
    parameter int CNT_W       = 27
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn_in,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic [N_BTN-1:0]         pending,
    output logic                     busy
);

    // state | meaning
    // IDLE  | waiting for any pending press
    // OFFER | evt_valid high, evt_id held until evt_ready
    // LOCK  | lockout countdown, edges on evt_id masked
    localparam int ID_W = $clog2(N_BTN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        LOCK  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [N_BTN-1:0]  s1_q, s2_q, s3_q;
    logic [N_BTN-1:0]  pending_q, pending_d;
    logic [N_BTN-1:0]  rise_w, mask_w;
    logic [ID_W-1:0]   evt_id_q, evt_id_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [ID_W-1:0]   pick_id;
    logic              pick_ok;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hs_w;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= btn_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_w = s2_q & ~s3_q;
    assign hs_w   = (state_q == OFFER) && evt_ready;

    // Edges on the button just served are ignored while it is locked out.
    always_comb begin
        mask_w = '0;
        if ((state_q == LOCK) || hs_w) begin
            mask_w[evt_id_q] = 1'b1;
        end
    end

    // Round-robin pick: first pending bit after the last grant, wrapping.
    always_comb begin
        int idx;
        pick_ok = 1'b0;
        pick_id = '0;
        idx     = 0;
        for (int k = 1; k <= N_BTN; k++) begin
            idx = (int'(last_grant_q) + k) % N_BTN;
            if (!pick_ok && pending_q[idx]) begin
                pick_ok = 1'b1;
                pick_id = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        evt_id_d     = evt_id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q | (rise_w & ~mask_w);
        case (state_q)
            IDLE: begin
                if (pick_ok) begin
                    evt_id_d = pick_id;
                    state_d  = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    pending_d[evt_id_q] = 1'b0;
                    last_grant_d        = evt_id_q;
                    cnt_d               = CNT_W'(LOCKOUT_CYC - 1);
                    state_d             = LOCK;
                end
            end
            LOCK: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
`ifdef BTN_REPEAT_EN
                    if (s2_q[evt_id_q]) begin
                        pending_d[evt_id_q] = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            evt_id_q     <= '0;
            last_grant_q <= ID_W'(N_BTN - 1);
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            evt_id_q     <= evt_id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign evt_valid = (state_q == OFFER);
    assign busy      = (state_q == OFFER) || (state_q == LOCK);
    assign evt_id    = evt_id_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with N_BTN=4, LOCKOUT_CYC=8 (default build, no repeat).
module tb_button_event_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] btn_in;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic [3:0] pending;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    button_event_arbiter #(
        .N_BTN(4),
        .LOCKOUT_CYC(8),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_id(evt_id),
        .pending(pending),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic quiet(input int n, output int hits, output logic [3:0] pend_or);
        hits = 0;
        pend_or = '0;
        repeat (n) begin
            tick();
            if (evt_valid === 1'b1) hits++;
            pend_or = pend_or | pending;
        end
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (n < max) begin
            tick();
            n++;
            if (evt_valid === 1'b1) break;
        end
    endtask

    initial begin
        int         hits;
        int         n;
        int         bad;
        logic [3:0] por;

        rst = 1'b0;
        btn_in = 4'b0000;
        evt_ready = 1'b1;
        #1;
        check("rst_valid", evt_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_id", evt_id, 0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (5) tick();
        check("idle_busy", busy, 0);

        // single press on button 2
        btn_in = 4'b0100;
        tick(); tick();
        check("s1_pend_early", pending, 4'b0000);
        tick();
        check("s1_pend", pending, 4'b0100);
        check("s1_valid_early", evt_valid, 0);
        tick();
        check("s1_valid", evt_valid, 1);
        check("s1_id", evt_id, 2);
        check("s1_busy_offer", busy, 1);
        tick();
        check("s1_valid_after_hs", evt_valid, 0);
        check("s1_pend_cleared", pending, 0);
        repeat (7) tick();
        check("s1_busy_last_lock", busy, 1);
        tick();
        check("s1_busy_end", busy, 0);
        quiet(30, hits, por);
        check("s1_no_repeat", hits, 0);
        btn_in = 4'b0000;
        repeat (5) tick();

        // bounce on button 1 during its lockout
        btn_in = 4'b0010;
        tick(); tick(); tick();
        check("s2_pend", pending, 4'b0010);
        btn_in = 4'b0000;
        tick();
        check("s2_valid", evt_valid, 1);
        check("s2_id", evt_id, 1);
        tick();
        check("s2_hs", evt_valid, 0);
        btn_in = 4'b0010;
        tick(); tick();
        btn_in = 4'b0000;
        tick(); tick();
        btn_in = 4'b0010;
        tick(); tick();
        btn_in = 4'b0000;
        quiet(25, hits, por);
        check("s2_no_event", hits, 0);
        check("s2_pend_never", por, 0);

        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // simultaneous presses served round-robin
        btn_in = 4'b1011;
        tick(); tick(); tick();
        check("s3_pend", pending, 4'b1011);
        btn_in = 4'b0000;
        tick();
        check("s3_first_id", evt_id, 0);
        check("s3_first_valid", evt_valid, 1);
        tick();
        wait_valid(20, n);
        check("s3_gap1", n, 9);
        check("s3_second_id", evt_id, 1);
        check("s3_pend_mid", pending, 4'b1010);
        tick();
        wait_valid(20, n);
        check("s3_gap2", n, 9);
        check("s3_third_id", evt_id, 3);
        tick();
        quiet(20, hits, por);
        check("s3_no_more", hits, 0);
        check("s3_pend_empty", por, 0);

        // backpressure on button 3
        evt_ready = 1'b0;
        btn_in = 4'b1000;
        tick(); tick(); tick(); tick();
        check("s4_valid", evt_valid, 1);
        check("s4_id", evt_id, 3);
        bad = 0;
        repeat (20) begin
            tick();
            if (!(evt_valid === 1'b1 && evt_id === 2'd3 && pending[3] === 1'b1)) bad++;
        end
        check("s4_stable", bad, 0);
        evt_ready = 1'b1;
        tick();
        check("s4_accepted", evt_valid, 0);
        check("s4_lock_busy", busy, 1);
        btn_in = 4'b0000;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("s4_lock_len", n, 8);

        // reset in the middle of LOCK
        btn_in = 4'b0001;
        tick(); tick(); tick();
        btn_in = 4'b0000;
        tick();
        check("s5_valid", evt_valid, 1);
        check("s5_id", evt_id, 0);
        tick();
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        check("s5_async_busy", busy, 0);
        check("s5_async_valid", evt_valid, 0);
        check("s5_async_pend", pending, 0);
        check("s5_async_id", evt_id, 0);
        tick(); tick();
        rst = 1'b1;
        quiet(20, hits, por);
        check("s5_no_event", hits, 0);
        check("s5_pend_empty", por, 0);
        check("s5_idle", busy, 0);

        // button held through reset release
        rst = 1'b0;
        btn_in = 4'b0100;
        tick(); tick();
        rst = 1'b1;
        wait_valid(10, n);
        check("s6_latency", n, 4);
        check("s6_id", evt_id, 2);
        tick();
        quiet(30, hits, por);
        check("s6_single_event", hits, 0);
        btn_in = 4'b0000;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
